cic_ctrl: RTL

Sequencer and output packer for one CIC decimator instance driven by a stereo PDM microphone.
- Holds the CIC configuration (comb_num, dec_num) in shadow registers and applies it only between runs.
- Drives the CIC reset and discards CIC outputs while the filter settles.
- Packs the interleaved left/right 32-bit CIC outputs into stereo pairs, delivered to the downstream consumer (FIFO/AXI bridge to PS) over a valid/ready handshake with overflow detection.

---
 rtl/cic_pkg.sv | 32 +++
 rtl/cic_pair_reg.sv | 59 +++++
 rtl/cic_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC sequencer slice.
//   cic_state_t : sequencer states (IDLE, RST, WARMUP, RUN, STOP)
//   CH_LEFT / CH_RIGHT : channel tag values carried with each CIC sample
//   COMB_W / DEC_W : widths of the CIC comb and decimation settings
//   cnt_w() : width of a counter that must hold values 0..max
package cic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        WARMUP,
        RUN,
        STOP
    } cic_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int unsigned COMB_W = 5;
    localparam int unsigned DEC_W  = 8;

    // Always at least one bit, so a maximum of 0 or 1 still yields a legal vector.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : cic_pkg

// File: rtl/cic_pair_reg.sv
// Single-entry valid/ready output register for stereo pairs.
//   clk, rst      : clock and synchronous active-high reset
//   load          : a completed pair is offered this cycle
//   load_left/right : the pair data offered with load
//   pair_ready    : consumer accepts the held pair this cycle
//   overflow_clr  : clears the sticky overflow flag
//   pair_valid, pair_left, pair_right : the held pair
//   overflow      : sticky, set when an offered pair could not be stored
module cic_pair_reg
    import cic_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_left,
    input  logic [DATA_W-1:0] load_right,
    input  logic              pair_ready,
    input  logic              overflow_clr,
    output logic              pair_valid,
    output logic [DATA_W-1:0] pair_left,
    output logic [DATA_W-1:0] pair_right,
    output logic              overflow
);

    logic slot_free;
    logic drop;

    // The slot can take a new pair when empty, or when the held pair leaves
    // in the same cycle (no bubble between back-to-back pairs).
    assign slot_free = !pair_valid || pair_ready;
    assign drop      = load && !slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_valid <= 1'b0;
            pair_left  <= '0;
            pair_right <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load && slot_free) begin
                pair_valid <= 1'b1;
                pair_left  <= load_left;
                pair_right <= load_right;
            end else if (pair_valid && pair_ready) begin
                pair_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear request leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule : cic_pair_reg

// File: rtl/cic_ctrl.sv
// Sequencer and output packer for one CIC decimator fed by a stereo PDM mic.
//   clk, rst        : clock and synchronous active-high reset
//   cfg_wr, cfg_comb_num, cfg_dec_num : shadow configuration write
//   cfg_rejected    : one-cycle pulse when cfg_wr arrives outside IDLE
//   start, stop     : acquisition control pulses
//   busy            : high in every state except IDLE
//   cic_rst, cic_comb_num, cic_dec_num : registered controls to the CIC
//   cic_data_out, cic_data_out_valid, cic_channel : interleaved CIC samples
//   pair_left, pair_right, pair_valid, pair_ready : stereo pair handshake
//   overflow, overflow_clr : sticky dropped-pair flag and its clear
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        RST_CYCLES   = 4,
    parameter int unsigned        WARMUP_PAIRS = 4,
    parameter logic [COMB_W-1:0]  DEF_COMB     = 5'd31,
    parameter logic [DEC_W-1:0]   DEF_DEC      = 8'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [COMB_W-1:0] cfg_comb_num,
    input  logic [DEC_W-1:0]  cfg_dec_num,
    output logic              cfg_rejected,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              cic_rst,
    output logic [COMB_W-1:0] cic_comb_num,
    output logic [DEC_W-1:0]  cic_dec_num,
    input  logic [DATA_W-1:0] cic_data_out,
    input  logic              cic_data_out_valid,
    input  logic              cic_channel,
    output logic [DATA_W-1:0] pair_left,
    output logic [DATA_W-1:0] pair_right,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int unsigned RC_W = cnt_w(RST_CYCLES);
    localparam int unsigned WC_W = cnt_w(WARMUP_PAIRS);

    localparam logic [RC_W-1:0] RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_PAIRS - 1);

    cic_state_t        state;
    logic [COMB_W-1:0] comb_shadow;
    logic [DEC_W-1:0]  dec_shadow;
    logic [RC_W-1:0]   rst_cnt;
    logic [WC_W-1:0]   warm_cnt;
    logic [DATA_W-1:0] left_hold;
    logic              hold;

    logic is_left;
    logic is_right;
    logic capturing;
    logic pair_load;

    assign is_left   = cic_data_out_valid && (cic_channel == CH_LEFT);
    assign is_right  = cic_data_out_valid && (cic_channel == CH_RIGHT);
    assign capturing = (state == RUN) || (state == STOP);
    // Pair completion is decoded combinationally so the output register
    // loads on the same edge that sees the right strobe.
    assign pair_load = capturing && is_right && hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cic_rst      <= 1'b1;
            busy         <= 1'b0;
            cfg_rejected <= 1'b0;
            comb_shadow  <= DEF_COMB;
            dec_shadow   <= DEF_DEC;
            cic_comb_num <= DEF_COMB;
            cic_dec_num  <= DEF_DEC;
            rst_cnt      <= '0;
            warm_cnt     <= '0;
            left_hold    <= '0;
            hold         <= 1'b0;
        end else begin
            cfg_rejected <= cfg_wr && (state != IDLE);

            case (state)
                IDLE: begin
                    if (cfg_wr) begin
                        comb_shadow <= cfg_comb_num;
                        dec_shadow  <= cfg_dec_num;
                    end
                    if (start && !stop) begin
                        state        <= RST;
                        busy         <= 1'b1;
                        cic_rst      <= 1'b1;
                        cic_comb_num <= cfg_wr ? cfg_comb_num : comb_shadow;
                        cic_dec_num  <= cfg_wr ? cfg_dec_num  : dec_shadow;
                        rst_cnt      <= '0;
                        warm_cnt     <= '0;
                        hold         <= 1'b0;
                    end
                end

                RST: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cic_rst <= 1'b1;
                    end else if (rst_cnt == RST_LAST) begin
                        state   <= WARMUP;
                        cic_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                WARMUP: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cic_rst  <= 1'b1;
                        warm_cnt <= '0;
                    end else if (is_right) begin
                        if (warm_cnt == WARM_LAST) begin
                            state <= RUN;
                            hold  <= 1'b0;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                end

                RUN, STOP: begin
                    if (is_left) begin
                        left_hold <= cic_data_out;
                        hold      <= 1'b1;
                    end else if (is_right) begin
                        hold <= 1'b0;
                    end

                    if (state == RUN) begin
                        if (stop) begin
                            state <= STOP;
                        end
                    end else if (!hold || is_right) begin
                        // Either nothing is half-built, or this strobe finishes it.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cic_rst <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cic_rst <= 1'b1;
                    hold    <= 1'b0;
                end
            endcase
        end
    end

    cic_pair_reg #(
        .DATA_W (DATA_W)
    ) u_pair_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (pair_load),
        .load_left    (left_hold),
        .load_right   (cic_data_out),
        .pair_ready   (pair_ready),
        .overflow_clr (overflow_clr),
        .pair_valid   (pair_valid),
        .pair_left    (pair_left),
        .pair_right   (pair_right),
        .overflow     (overflow)
    );

endmodule : cic_ctrl
